// File: rtl/mem_axi_lite_master.sv
// mem_axi_lite_master: turns single-beat core load/store requests into one
// AXI-lite read or write transaction at a time. The request is captured on
// acceptance, the AXI channels are driven from registered state, and a
// one-cycle response pulse is returned to the core.
module mem_axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rstn,
    // core-side request/response
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_wen,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     req_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   req_wmask,
    output logic                              resp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_rdata,
    output logic                              resp_err,
    // AXI-lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr,
    output logic                              awvalid,
    input  logic                              awready,
    // AXI-lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]     wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb,
    output logic                              wvalid,
    input  logic                              wready,
    // AXI-lite write response
    input  logic [1:0]                        bresp,
    input  logic                              bvalid,
    output logic                              bready,
    // AXI-lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr,
    output logic                              arvalid,
    input  logic                              arready,
    // AXI-lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                        rresp,
    input  logic                              rvalid,
    output logic                              rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_A,
        S_RD_D,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wmask_q, wmask_d;
    logic            wen_q, wen_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic aw_fire, w_fire;

    assign aw_fire = awvalid_q & awready;
    assign w_fire  = wvalid_q & wready;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        wen_d        = wen_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                // req_ready_q is low only in the first cycle after reset
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wmask_d     = req_wmask;
                    wen_d       = req_wen;
                    req_ready_d = 1'b0;
                    if (req_wen) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently; move on once both have
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    state_d  = S_WR_B;
                    bready_d = 1'b1;
                end
            end
            S_WR_B: begin
                if (bvalid) begin
                    // SLVERR (2'b10) and DECERR (2'b11) are errors
                    resp_err_d   = (bresp == 2'b10) || (bresp == 2'b11);
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RD_A: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                if (rvalid) begin
                    rdata_d      = rdata;
                    resp_err_d   = (rresp == 2'b10) || (rresp == 2'b11);
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b0;
                aw_done_d    = 1'b0;
                w_done_d     = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                awvalid_d    = 1'b0;
                wvalid_d     = 1'b0;
                bready_d     = 1'b0;
                arvalid_d    = 1'b0;
                rready_d     = 1'b0;
                resp_valid_d = 1'b0;
                aw_done_d    = 1'b0;
                w_done_d     = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wen_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            wen_q        <= wen_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    // Last read value is kept; a write's response cycle shows zero
    assign resp_rdata = (resp_valid_q && wen_q) ? '0 : rdata_q;

    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wmask_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign araddr  = addr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule
